// File: rtl/cmp_feed_if.sv
// Start/status, memory-port and accelerator-port signals of cmp_feed.
// The master modport is the cmp_feed side; slave is the environment side.
interface cmp_feed_if #(
   parameter int WORDS = 96
);
   logic                  start;
   logic [15:0]           src_addr;
   logic [15:0]           dst_addr;
   logic [15:0]           mem_addr;
   logic                  mem_rden;
   logic [15:0]           mem_rdata;
   logic                  mem_wren;
   logic [15:0]           mem_wdata;
   logic                  acc_wren;
   logic [WORDS*16-1:0]   acc_bitmap;
   logic                  acc_done;
   logic [15:0]           acc_lshift;
   logic [15:0]           acc_dshift;
   logic [15:0]           acc_hscale;
   logic [15:0]           acc_vscale;
   logic                  busy;
   logic                  finished;
   logic                  error;

   modport master (
      input  start, src_addr, dst_addr, mem_rdata,
      input  acc_done, acc_lshift, acc_dshift, acc_hscale, acc_vscale,
      output mem_addr, mem_rden, mem_wren, mem_wdata,
      output acc_wren, acc_bitmap, busy, finished, error
   );

   modport slave (
      output start, src_addr, dst_addr, mem_rdata,
      output acc_done, acc_lshift, acc_dshift, acc_hscale, acc_vscale,
      input  mem_addr, mem_rden, mem_wren, mem_wdata,
      input  acc_wren, acc_bitmap, busy, finished, error
   );
endinterface

// File: rtl/cmp_feed.sv
// Reads a WORDS x 16-bit bitmap, pulses it into the compare accelerator and writes its four results back.
// Launch WORDS+2 cycles after start; writes 1..4 cycles after acc_done, finished at +5; no backpressure, memory is fixed-latency.
module cmp_feed #(
   parameter int WORDS   = 96,
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   cmp_feed_if.master  bus
);
   localparam int CW = $clog2(WORDS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_WRITE, S_DONE, S_ERR
   } state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [TW-1:0]       wcnt;
   logic [15:0]         src;
   logic [15:0]         dst;
   logic [47:0]         res;
   logic [WORDS*16-1:0] bitmap;
   logic [15:0]         mem_addr;
   logic [15:0]         mem_wdata;
   logic                mem_rden;
   logic                mem_wren;
   logic                acc_wren;
   logic                busy;
   logic                finished;
   logic                error;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         wcnt      <= '0;
         src       <= '0;
         dst       <= '0;
         res       <= '0;
         bitmap    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rden  <= 1'b0;
         mem_wren  <= 1'b0;
         acc_wren  <= 1'b0;
         busy      <= 1'b0;
         finished  <= 1'b0;
         error     <= 1'b0;
      end else begin
         // Strobes and bus values are one-cycle unless re-armed below
         mem_rden  <= 1'b0;
         mem_wren  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         acc_wren  <= 1'b0;
         finished  <= 1'b0;
         case (state)
            S_IDLE, S_ERR: begin
               if (bus.start) begin
                  src      <= bus.src_addr;
                  dst      <= bus.dst_addr;
                  error    <= 1'b0;
                  bitmap   <= '0;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  mem_rden <= 1'b1;
                  mem_addr <= bus.src_addr;
                  state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               // Read data trails the address by one cycle, so word cnt-1 arrives now
               if (cnt != '0)
                  bitmap[16*(int'(cnt)-1) +: 16] <= bus.mem_rdata;
               if (cnt == CW'(WORDS)) begin
                  acc_wren <= 1'b1;
                  state    <= S_LAUNCH;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (cnt < CW'(WORDS - 1)) begin
                     mem_rden <= 1'b1;
                     mem_addr <= src + 16'(cnt) + 16'd1;
                  end
               end
            end
            S_LAUNCH: begin
               wcnt  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.acc_done) begin
                  res       <= {bus.acc_vscale, bus.acc_hscale, bus.acc_dshift};
                  cnt       <= '0;
                  mem_wren  <= 1'b1;
                  mem_addr  <= dst;
                  mem_wdata <= bus.acc_lshift;
                  state     <= S_WRITE;
               end else if (wcnt == TW'(TIMEOUT - 1)) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_ERR;
               end else begin
                  wcnt <= wcnt + TW'(1);
               end
            end
            S_WRITE: begin
               if (cnt == CW'(3)) begin
                  finished <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  cnt       <= cnt + CW'(1);
                  mem_wren  <= 1'b1;
                  mem_addr  <= dst + 16'(cnt) + 16'd1;
                  mem_wdata <= res[15:0];
                  res       <= {16'd0, res[47:16]};
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_addr   = mem_addr;
   assign bus.mem_rden   = mem_rden;
   assign bus.mem_wren   = mem_wren;
   assign bus.mem_wdata  = mem_wdata;
   assign bus.acc_wren   = acc_wren;
   assign bus.acc_bitmap = bitmap;
   assign bus.busy       = busy;
   assign bus.finished   = finished;
   assign bus.error      = error;
endmodule
